mem_access_seq: RTL and testbench

Multicycle memory access sequencer between the datapath and the word-wide synchronous data memory. It performs loads (captures the raw memory word for the downstream load-size stage) and stores. Word stores are written directly. Half and byte stores are done as read-modify-write: read the old word, merge the new lanes, write back. It presents one registered request/done handshake to the control unit and drives the memory address, write-enable and write-data lines.

---
 rtl/mem_access_seq.sv | 121 ++++++++++++
 tb/tb_mem_access_seq.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mem_access_seq.sv
// mem_access_seq: multicycle load/store sequencer for a word-wide synchronous
// data memory. Sub-word stores use read-modify-write. All outputs are registered.
// Optional feature: define MISALIGN_TRAP_EN to trap misaligned word/half accesses.
module mem_access_seq #(
  parameter int MEM_LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_wr,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        misalign,
  output logic [31:0] mem_addr,
  output logic        mem_wr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {IDLE, READ, MERGE, WRITE, DONE} state_t;

  // Only the fields the merge/sequencing needs are kept after acceptance.
  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [1:0]  lane;
    logic [15:0] wdata;
  } req_t;

  localparam logic [2:0] LAST = 3'(MEM_LAT - 1);

  state_t      state, nxt;
  req_t        rq;
  logic [2:0]  cnt;
  logic [31:0] old;
  logic        trap;
  logic        wordsz;

  assign wordsz = (req_size == 2'd0) || (req_size == 2'd3);

  // Replace the selected byte/half lane of the old word (little-endian lanes).
  function automatic logic [31:0] merge(input logic [31:0] w, input req_t r);
    logic [31:0] m;
    m = w;
    if (r.size == 2'd2) m[{r.lane, 3'b000} +: 8]  = r.wdata[7:0];
    else                m[{r.lane[1], 4'b0000} +: 16] = r.wdata[15:0];
    return m;
  endfunction

`ifdef MISALIGN_TRAP_EN
  // Misaligned word (any low bits set) or half (odd address) access traps.
  always_comb trap = (wordsz && (req_addr[1:0] != 2'b00)) ||
                     ((req_size == 2'd1) && req_addr[0]);

  // Flag is set on acceptance so it accompanies the done pulse, cleared after.
  always_ff @(posedge clk or posedge reset)
    if (reset)                          misalign <= 1'b0;
    else if (state == IDLE && req_valid) misalign <= trap;
    else if (state == DONE)             misalign <= 1'b0;
`else
  assign trap     = 1'b0;
  assign misalign = 1'b0;
`endif

  // Next-state logic.
  always_comb begin
    nxt = state;
    case (state)
      IDLE:  if (req_valid) begin
               if (trap)                 nxt = DONE;
               else if (req_wr && wordsz) nxt = WRITE;
               else                       nxt = READ;
             end
      READ:  if (cnt == LAST) nxt = rq.wr ? MERGE : DONE;
      MERGE: nxt = WRITE;
      WRITE: nxt = DONE;
      DONE:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // State, latency counter, latched request and registered outputs.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state     <= IDLE;
      cnt       <= 3'd0;
      rq        <= '0;
      old       <= 32'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rdata     <= 32'd0;
      mem_addr  <= 32'd0;
      mem_wr    <= 1'b0;
      mem_wdata <= 32'd0;
    end else begin
      state  <= nxt;
      busy   <= (nxt != IDLE);
      done   <= (nxt == DONE);
      mem_wr <= (nxt == WRITE);
      cnt    <= (state == READ && cnt != LAST) ? cnt + 3'd1 : 3'd0;
      case (state)
        IDLE:  if (req_valid) begin
                 rq       <= '{wr: req_wr, size: req_size, lane: req_addr[1:0],
                               wdata: req_wdata[15:0]};
                 mem_addr <= {req_addr[31:2], 2'b00};
                 if (req_wr) mem_wdata <= req_wdata;
               end
        READ:  if (cnt == LAST) begin
                 old <= mem_rdata;
                 if (!rq.wr) rdata <= mem_rdata;
               end
        MERGE: mem_wdata <= merge(old, rq);
        default: ;
      endcase
    end

endmodule

// File: tb/tb_mem_access_seq.sv
// Self-checking bench for mem_access_seq: vector table + scoreboard queue,
// plus hand sequences for reset mid-access and back-to-back requests.
module tb_mem_access_seq;
  localparam int L = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_wr;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        busy, done, misalign, mem_wr;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_access_seq #(.MEM_LAT(L)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_wr(req_wr),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .busy(busy), .done(done), .rdata(rdata), .misalign(misalign),
    .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Memory model: read data is garbage until MEM_LAT cycles of the access.
  logic [31:0] mem [0:255];
  logic        pl_en = 1'b0;
  logic [31:0] pl_addr = 32'd0, pl_dat = 32'd0;
  int          rcnt = 0;

  always @(posedge clk) begin
    if (pl_en)       mem[pl_addr[9:2]] <= pl_dat;
    else if (mem_wr) mem[mem_addr[9:2]] <= mem_wdata;
    rcnt <= busy ? rcnt + 1 : 0;
  end
  assign mem_rdata = (rcnt >= L - 1) ? mem[mem_addr[9:2]] : 32'hBAD0_BAD0;

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr, wdata, old, word;
    int          dcyc;
    logic        mis;
  } vec_t;

  typedef struct {
    logic [31:0] rd, word;
    logic        mis;
    int          dcyc, nwr;
  } exp_t;

  exp_t        sb[$];
  vec_t        tv[12];
  int          nvec = 0, nerr = 0;
  logic [31:0] last_rd = 32'd0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk); pl_en = 1'b1; pl_addr = a; pl_dat = d;
    @(negedge clk); pl_en = 1'b0;
  endtask

  task automatic run(input vec_t v);
    exp_t        e;
    int          dc, nwr, wc;
    logic [31:0] wd, rd;
    logic        ms;
    preload(v.addr, v.old);
    if (!v.wr && !v.mis) last_rd = v.word;
    e.rd = last_rd; e.word = v.word; e.mis = v.mis; e.dcyc = v.dcyc;
    e.nwr = (v.wr && !v.mis) ? 1 : 0;
    sb.push_back(e);
    @(negedge clk);
    req_valid = 1'b1; req_wr = v.wr; req_size = v.size;
    req_addr = v.addr; req_wdata = v.wdata;
    @(negedge clk);
    // Scramble request lines: the DUT must use its latched copy.
    req_valid = 1'b0; req_wr = 1'($urandom); req_size = 2'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    chk("mem_addr", mem_addr, v.addr & ~32'h3);
    dc = -1; nwr = 0; wc = -1; wd = 32'd0; rd = 32'd0; ms = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (mem_wr) begin nwr++; wd = mem_wdata; wc = c; end
      if (done) begin dc = c; ms = misalign; rd = rdata; break; end
      @(negedge clk);
    end
    e = sb.pop_front();
    chk("done_cycle", 32'(dc), 32'(e.dcyc));
    chk("misalign", {31'd0, ms}, {31'd0, e.mis});
    chk("rdata", rd, e.rd);
    chk("wr_pulses", 32'(nwr), 32'(e.nwr));
    if (e.nwr > 0) begin
      chk("wr_data", wd, e.word);
      chk("wr_cycle", 32'(wc), 32'(e.dcyc - 1));
    end
    @(negedge clk);
    chk("mem_word", mem[v.addr[9:2]], e.word);
    chk("busy_idle", {31'd0, busy}, 32'd0);
  endtask

  int d1, d2;

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_size = 2'd0;
    req_addr = 32'd0; req_wdata = 32'd0;

    //           wr size addr    wdata         old           word         dcyc mis
    tv[0]  = '{1'b0, 2'd0, 32'h104, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 3, 1'b0};
    tv[1]  = '{1'b1, 2'd0, 32'h020, 32'h12345678, 32'h00000000, 32'h12345678, 2, 1'b0};
    tv[2]  = '{1'b1, 2'd2, 32'h023, 32'h000000EE, 32'hAABBCCDD, 32'hEEBBCCDD, 5, 1'b0};
    tv[3]  = '{1'b1, 2'd1, 32'h042, 32'hFFFF5566, 32'h11223344, 32'h55663344, 5, 1'b0};
    tv[4]  = '{1'b1, 2'd2, 32'h060, 32'hABCDEF22, 32'h11111111, 32'h11111122, 5, 1'b0};
    tv[5]  = '{1'b1, 2'd2, 32'h061, 32'h00000033, 32'h00000000, 32'h00003300, 5, 1'b0};
    tv[6]  = '{1'b1, 2'd2, 32'h062, 32'h00000000, 32'hFFFFFFFF, 32'hFF00FFFF, 5, 1'b0};
    tv[7]  = '{1'b1, 2'd1, 32'h080, 32'h00001234, 32'hCAFEBABE, 32'hCAFE1234, 5, 1'b0};
    tv[8]  = '{1'b1, 2'd3, 32'h090, 32'h0BADF00D, 32'h5A5A5A5A, 32'h0BADF00D, 2, 1'b0};
    tv[9]  = '{1'b0, 2'd0, 32'h1F0, 32'h0,        32'h76543210, 32'h76543210, 3, 1'b0};
`ifdef MISALIGN_TRAP_EN
    tv[10] = '{1'b0, 2'd0, 32'h102, 32'h0,        32'h0F0F0F0F, 32'h0F0F0F0F, 1, 1'b1};
    tv[11] = '{1'b1, 2'd1, 32'h0A3, 32'h0000BEEF, 32'h01020304, 32'h01020304, 1, 1'b1};
`else
    tv[10] = '{1'b0, 2'd0, 32'h102, 32'h0,        32'h0F0F0F0F, 32'h0F0F0F0F, 3, 1'b0};
    tv[11] = '{1'b1, 2'd1, 32'h0A3, 32'h0000BEEF, 32'h01020304, 32'hBEEF0304, 5, 1'b0};
`endif

    repeat (2) @(negedge clk);
    chk("rst_busy",      {31'd0, busy},     32'd0);
    chk("rst_done",      {31'd0, done},     32'd0);
    chk("rst_misalign",  {31'd0, misalign}, 32'd0);
    chk("rst_mem_wr",    {31'd0, mem_wr},   32'd0);
    chk("rst_rdata",     rdata,     32'd0);
    chk("rst_mem_addr",  mem_addr,  32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) run(tv[i]);

    // Reset in the middle of READ: outputs clear immediately.
    @(negedge clk);
    req_valid = 1'b1; req_wr = 1'b0; req_size = 2'd0; req_addr = 32'h104;
    @(negedge clk); req_valid = 1'b0;
    chk("midread_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1; #1;
    chk("midread_rst_busy",   {31'd0, busy},   32'd0);
    chk("midread_rst_done",   {31'd0, done},   32'd0);
    chk("midread_rst_mem_wr", {31'd0, mem_wr}, 32'd0);
    chk("midread_rst_rdata",  rdata,           32'd0);
    @(negedge clk); reset = 1'b0; last_rd = 32'd0;
    run(tv[0]);

    // Reset while mem_wr is high: the write is abandoned.
    preload(32'h2C, 32'h44444444);
    @(negedge clk);
    req_valid = 1'b1; req_wr = 1'b1; req_size = 2'd2; req_addr = 32'h2C; req_wdata = 32'h99;
    @(negedge clk); req_valid = 1'b0;
    for (int c = 0; c < 10 && !mem_wr; c++) @(negedge clk);
    chk("midwrite_reached", {31'd0, mem_wr}, 32'd1);
    reset = 1'b1; #1;
    chk("midwrite_rst_mem_wr", {31'd0, mem_wr}, 32'd0);
    chk("midwrite_rst_done",   {31'd0, done},   32'd0);
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    chk("midwrite_mem_kept", mem[32'h2C >> 2], 32'h44444444);

    // req_valid held high: DONE ignores it, IDLE accepts the next one.
    @(negedge clk);
    req_valid = 1'b1; req_wr = 1'b0; req_size = 2'd0; req_addr = 32'h104;
    d1 = -1; d2 = -1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 4) chk("b2b_idle_busy", {31'd0, busy}, 32'd0);
      if (done) begin
        if (d1 < 0) d1 = c;
        else if (d2 < 0) d2 = c;
      end
    end
    req_valid = 1'b0;
    chk("b2b_first_done",  32'(d1), 32'd3);
    chk("b2b_second_done", 32'(d2), 32'd7);
    chk("b2b_rdata", rdata, 32'hDEADBEEF);
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
